mem_moc_responder: RTL and testbench
====================================

MEM_MOC_RESPONDER -- requirements
Module: mem_moc_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, wait cycles between request capture and access completion (0..15).
REQ-002 SHALL have parameter DEPTH, default 256, memory size in bytes (power of two).
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MFA  input  1  memory-function-activate request from the control unit.
REQ-006 SHALL have port RW  input  1  1 = read, 0 = write.
REQ-007 SHALL have port DataType  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port SignExt  input  1  sign-extend byte/halfword reads (LDRSB/LDRSH).
REQ-009 SHALL have port Address  input  $clog2(DEPTH)  byte address.
REQ-010 SHALL have port DataIn  input  32  write data, LSB-aligned.
REQ-011 SHALL have port DataOut  output  32  read data, LSB-aligned.
REQ-012 SHALL have port MOC  output  1  memory-operation-complete to the control unit.
REQ-013 SHALL have port Err  output  1  reserved DataType or, with check enabled, misalignment.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE.
REQ-015 IDLE: MFA sampled high at edge N -> latch RW, DataType, SignExt, Address, DataIn; go BUSY (LATENCY>0) or DONE (LATENCY=0).
REQ-016 BUSY: down-counter loaded with LATENCY-1 at capture; at zero -> DONE; access performed on the BUSY->DONE edge.
REQ-017 MOC SHALL rise at edge N+LATENCY+1 and hold high while in DONE.
REQ-018 DONE: stay while MFA high; MFA low -> IDLE, MOC low next edge; new request needs MFA sampled low once first.
REQ-019 MFA low during BUSY -> abort to IDLE, no write, DataOut unchanged, MOC never asserted.
REQ-020 Little-endian: byte k of word at Address+k, addresses wrap modulo DEPTH.
REQ-021 Write byte/halfword/word SHALL modify only 1/2/4 bytes; other bytes untouched.
REQ-022 Read SHALL zero-extend byte/halfword unless latched SignExt=1, then replicate bit 7/15.
REQ-023 DataOut SHALL update only on a completed read and hold until the next completed read.
REQ-024 DataType 11: no memory change, DataOut unchanged, Err=1 with MOC; Err cleared on leaving DONE.
REQ-025 Inputs other than MFA SHALL be ignored outside IDLE (latched copy used).

Reset
REQ-026 Reset_n low SHALL asynchronously force IDLE, MOC=0, Err=0, DataOut=0, counter=0.
REQ-027 Reset mid-BUSY SHALL abort the access with no memory write; memory array contents are not reset.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: halfword with Address[0]=1 or word with Address[1:0]!=0 SHALL set Err, skip access, still complete MOC handshake.
REQ-029 MEM_ALIGN_CHECK_EN undefined: misaligned accesses proceed byte-wise with wrap per REQ-020, Err only for DataType 11.

Structure
REQ-030 Package mem_pkg SHALL hold DataType encodings (DT_BYTE, DT_HALF, DT_WORD, DT_RSVD) and the FSM state enum.
REQ-031 Sub-module mem_byte_array SHALL hold DEPTH bytes with 4 byte-lane write enables and a 4-byte wrapped read port; FSM, counter, extension and checks stay in mem_moc_responder.

Verification
REQ-032 Word write 0xDEADBEEF @0x10, LATENCY=2, MFA at edge 0 -> MOC high from edge 3; word read @0x10 -> DataOut=0xDEADBEEF.
REQ-033 Byte read @0x10 SignExt=1 -> 0xFFFFFFEF; halfword read @0x12 SignExt=0 -> 0x0000DEAD.
REQ-034 Byte write 0x55 @0x11 -> word read @0x10 = 0xDEAD55EF.
REQ-035 MFA dropped at edge 1 of a word write 0x12345678 @0x20 -> MOC never high, word @0x20 unchanged.
REQ-036 Word read @0x22: with MEM_ALIGN_CHECK_EN -> Err=1, MOC=1, DataOut unchanged; without -> bytes 0x22..0x25 assembled, Err=0.
REQ-037 Reset_n pulsed low mid-BUSY of a write -> MOC=0, IDLE, target bytes unchanged; LATENCY=0 build -> MOC at edge 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: data-type encodings, FSM states
// and small helpers for lane selection and read-data extension.
package mem_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;
    localparam logic [1:0] DT_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_t;

    // Byte-lane write mask for a given access size.
    function automatic logic [3:0] lane_mask(input logic [1:0] dt);
        logic [3:0] m;
        case (dt)
            DT_BYTE: m = 4'b0001;
            DT_HALF: m = 4'b0011;
            DT_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Zero- or sign-extend the low byte/halfword of the raw 4-byte read.
    function automatic logic [31:0] extend_rd(input logic [31:0] raw, input logic [1:0] dt,
                                              input logic sext);
        logic [31:0] r;
        case (dt)
            DT_BYTE: r = {{24{sext & raw[7]}}, raw[7:0]};
            DT_HALF: r = {{16{sext & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-organised storage: four independent byte-lane writes and a 4-byte
// little-endian read, both wrapping modulo DEPTH. Contents are never reset.
module mem_byte_array #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     Clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane_addr [4];

    // Lane k addresses byte addr+k, wrapping through the AW-bit add.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr + AW'(k);
        end
    end

    // Per-lane byte writes.
    always_ff @(posedge Clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) mem[lane_addr[k]] <= wdata[8*k +: 8];
        end
    end

    // Assemble the wrapped little-endian read word.
    always_comb begin
        rdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            rdata[8*k +: 8] = mem[lane_addr[k]];
        end
    end

endmodule

// File: rtl/mem_moc_responder.sv
// MFA/MOC handshake memory responder with configurable access latency.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses as errors (access skipped, handshake still completes).
module mem_moc_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     MFA,
    input  logic                     RW,
    input  logic [1:0]               DataType,
    input  logic                     SignExt,
    input  logic [$clog2(DEPTH)-1:0] Address,
    input  logic [31:0]              DataIn,
    output logic [31:0]              DataOut,
    output logic                     MOC,
    output logic                     Err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam bit          ZeroLat  = (LATENCY == 0);
    localparam logic [3:0]  CntInit  = ZeroLat ? 4'd0 : 4'(LATENCY - 1);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          rw_q, sext_q, flt_q;
    logic [1:0]    dt_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          moc_q, err_q;
    logic [31:0]   dout_q;

    logic          op_rw, op_sext, in_idle, access_go, fault, misaligned;
    logic [1:0]    op_dt;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_wdata, rdata;
    logic [3:0]    we;

    // Operands come straight from the inputs in IDLE (zero-latency capture
    // edge), otherwise from the latched copy.
    always_comb begin
        in_idle  = (state_q == StIdle);
        op_rw    = in_idle ? RW       : rw_q;
        op_dt    = in_idle ? DataType : dt_q;
        op_sext  = in_idle ? SignExt  : sext_q;
        op_addr  = in_idle ? Address  : addr_q;
        op_wdata = in_idle ? DataIn   : wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((op_dt == DT_HALF) && op_addr[0]) ||
                     ((op_dt == DT_WORD) && (op_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        fault     = (op_dt == DT_RSVD) || misaligned;
        // Reset_n gating keeps a held MFA from writing while reset is asserted.
        access_go = Reset_n && MFA &&
                    ((in_idle && ZeroLat) || ((state_q == StBusy) && (cnt_q == 4'd0)));
        we        = (access_go && !op_rw && !fault) ? lane_mask(op_dt) : 4'b0000;
    end

    mem_byte_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .Clk   (Clk),
        .we    (we),
        .addr  (op_addr),
        .wdata (op_wdata),
        .rdata (rdata)
    );

    // Handshake FSM with latency counter, request latch and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            dt_q    <= DT_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            flt_q   <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            // MOC/Err follow DONE one edge late and drop as soon as MFA is seen low.
            moc_q <= (state_q == StDone) && MFA;
            err_q <= (state_q == StDone) && MFA && flt_q;
            if (access_go && op_rw && !fault) dout_q <= extend_rd(rdata, op_dt, op_sext);
            case (state_q)
                StIdle: begin
                    if (MFA) begin
                        rw_q    <= RW;
                        dt_q    <= DataType;
                        sext_q  <= SignExt;
                        addr_q  <= Address;
                        wdata_q <= DataIn;
                        flt_q   <= fault;
                        cnt_q   <= CntInit;
                        state_q <= ZeroLat ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    if (!MFA) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    if (!MFA) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_moc_responder.sv
// Self-checking bench: table of transactions through a scoreboard queue,
// plus hand-written abort, misalignment, reset and zero-latency sequences.
module tb_mem_moc_responder;

    localparam int unsigned TbLat = 2;

    typedef struct packed {
        logic        rw;
        logic [1:0]  dt;
        logic        sext;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_err;
    } txn_t;

    typedef struct packed {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n, mfa, mfa0, rw, sext;
    logic [1:0]  dt;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout, dout0;
    logic        moc, err, moc0, err0;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    txn_t tbl [13];

    always #5 Clk = ~Clk;

    mem_moc_responder #(.LATENCY(TbLat), .DEPTH(256)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .MFA(mfa), .RW(rw), .DataType(dt), .SignExt(sext),
        .Address(addr), .DataIn(din), .DataOut(dout), .MOC(moc), .Err(err)
    );

    mem_moc_responder #(.LATENCY(0), .DEPTH(256)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .MFA(mfa0), .RW(rw), .DataType(dt), .SignExt(sext),
        .Address(addr), .DataIn(din), .DataOut(dout0), .MOC(moc0), .Err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t);
        int   edges;
        bit   seen;
        exp_t e;
        rw = t.rw; dt = t.dt; sext = t.sext; addr = t.addr; din = t.wdata;
        mfa = 1'b1;
        exp_q.push_back('{dout: t.exp_dout, err: t.exp_err});
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge Clk); #1;
            edges++;
            if (moc) seen = 1'b1;
            else begin
                // Non-MFA inputs must be ignored once the request is latched.
                rw = 1'($urandom); dt = 2'($urandom); sext = 1'($urandom);
                addr = 8'($urandom); din = $urandom;
            end
        end
        e = exp_q.pop_front();
        if (!seen) begin
            check("moc_timeout", 32'(seen), 32'd1);
        end else begin
            check("moc_latency", 32'(edges), 32'(TbLat + 2));
            check("dout", dout, e.dout);
            check("err", 32'(err), 32'(e.err));
        end
        mfa = 1'b0;
        @(posedge Clk); #1;
        check("moc_release", 32'(moc), 32'd0);
        check("err_release", 32'(err), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 1'b1, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 1'b0, 8'h12, 32'h0,        32'h0000DEAD, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 8'h11, 32'hAAAAAA55, 32'h0000DEAD, 1'b0};
        tbl[5]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 1'b1, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 1'b1, 8'h11, 32'h0,        32'h00000055, 1'b0};
        tbl[8]  = '{1'b0, 2'b10, 1'b0, 8'h20, 32'hCAFEF00D, 32'h00000055, 1'b0};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 8'h24, 32'h03020100, 32'h00000055, 1'b0};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 8'h20, 32'hFFFFFFFF, 32'h00000055, 1'b1};
        tbl[11] = '{1'b1, 2'b10, 1'b0, 8'h20, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 1'b0, 8'h23, 32'h0,        32'h000000CA, 1'b0};

        Reset_n = 1'b0; mfa = 1'b0; mfa0 = 1'b0;
        rw = 1'b0; dt = 2'b00; sext = 1'b0; addr = 8'h00; din = 32'h0;
        #12;
        check("rst_moc", 32'(moc), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", dout, 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 13; i++) run_txn(tbl[i]);

        // Abort: MFA sampled low at edge 1 of a word write.
        begin
            bit moc_seen;
            moc_seen = 1'b0;
            rw = 1'b0; dt = 2'b10; addr = 8'h20; din = 32'h12345678; mfa = 1'b1;
            @(posedge Clk); #1;
            mfa = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge Clk); #1;
                if (moc) moc_seen = 1'b1;
            end
            check("abort_moc", 32'(moc_seen), 32'd0);
            check("abort_dout", dout, 32'h000000CA);
        end
        run_txn('{1'b1, 2'b10, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 1'b0});

        // Misaligned word read spanning 0x22..0x25.
`ifdef MEM_ALIGN_CHECK_EN
        run_txn('{1'b1, 2'b10, 1'b0, 8'h22, 32'h0, 32'hCAFEF00D, 1'b1});
`else
        run_txn('{1'b1, 2'b10, 1'b0, 8'h22, 32'h0, 32'h0100CAFE, 1'b0});
`endif

        // Reset pulsed mid-BUSY of a write.
        rw = 1'b0; dt = 2'b10; addr = 8'h24; din = 32'hA5A5A5A5; mfa = 1'b1;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #2;
        check("rstbusy_moc", 32'(moc), 32'd0);
        check("rstbusy_dout", dout, 32'd0);
        mfa = 1'b0;
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_txn('{1'b1, 2'b10, 1'b0, 8'h24, 32'h0, 32'h03020100, 1'b0});

`ifndef MEM_ALIGN_CHECK_EN
        // Halfword write wrapping from the top byte to address 0.
        run_txn('{1'b0, 2'b01, 1'b0, 8'hFF, 32'h0000BEEF, 32'h03020100, 1'b0});
        run_txn('{1'b1, 2'b00, 1'b0, 8'hFF, 32'h0, 32'h000000EF, 1'b0});
        run_txn('{1'b1, 2'b00, 1'b0, 8'h00, 32'h0, 32'h000000BE, 1'b0});
`endif

        // Zero-latency instance: MOC at edge 1 after capture at edge 0.
        rw = 1'b0; dt = 2'b10; sext = 1'b0; addr = 8'h40; din = 32'h11223344; mfa0 = 1'b1;
        @(posedge Clk); #1;
        check("lat0_edge0", 32'(moc0), 32'd0);
        @(posedge Clk); #1;
        check("lat0_edge1", 32'(moc0), 32'd1);
        mfa0 = 1'b0;
        @(posedge Clk); #1;
        check("lat0_release", 32'(moc0), 32'd0);
        rw = 1'b1; mfa0 = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("lat0_rd_moc", 32'(moc0), 32'd1);
        check("lat0_rd_dout", dout0, 32'h11223344);
        check("lat0_rd_err", 32'(err0), 32'd0);
        mfa0 = 1'b0;
        @(posedge Clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
